// File: rtl/tinyriscv_pkg.sv
// Shared bus widths and the RIB arbiter state encoding.
package tinyriscv_pkg;

    localparam int MemAddrBus = 32;
    localparam int MemBus     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } RibArbState_e;

endpackage

// File: rtl/rib_prio_pick.sv
// Lowest-index picker over (req & mask), optionally skipping one index.
module rib_prio_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic          excl_en,
    input  logic [IW-1:0] excl_idx,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest eligible index is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && mask[i] && !(excl_en && excl_idx == IW'(i))) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rib_arbiter.sv
// Fixed-priority RIB arbiter with per-master starvation promotion.
// One locked grant per request/ready transaction; back-to-back re-arbitration
// happens in the ready cycle with the finishing master excluded.
module rib_arbiter
    import tinyriscv_pkg::*;
#(
    parameter int                    NumMasters = 3,
    parameter int                    MaxWait    = 8,
    parameter logic [NumMasters-1:0] CoreMask   = NumMasters'(3'b110)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumMasters-1:0][MemAddrBus-1:0] m_addr_i,
    input  logic [NumMasters-1:0][MemBus-1:0]     m_data_i,
    input  logic [NumMasters-1:0]                 m_req_i,
    input  logic [NumMasters-1:0]                 m_we_i,
    output logic [NumMasters-1:0][MemBus-1:0]     m_data_o,
    output logic [NumMasters-1:0]                 m_ready_o,
    output logic [MemAddrBus-1:0]                 s_addr_o,
    output logic [MemBus-1:0]                     s_data_o,
    output logic                                  s_we_o,
    output logic                                  s_req_o,
    input  logic [MemBus-1:0]                     s_data_i,
    input  logic                                  s_ready_i,
    output logic                                  hold_flag_o
);

    localparam int IW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int CW = $clog2(MaxWait + 1);

    RibArbState_e                    state_q, state_d;
    logic [IW-1:0]                   gnt_q, gnt_d;
    logic [NumMasters-1:0][CW-1:0]   cnt_q;
    logic [NumMasters-1:0]           urgent;
    logic                            busy, load, any_vld;
    logic                            urg_vld, pln_vld;
    logic [IW-1:0]                   urg_idx, pln_idx, win;

    assign busy = (state_q == BUSY);

    // A master is urgent once its wait counter has saturated.
    always_comb begin
        for (int i = 0; i < NumMasters; i++) urgent[i] = (cnt_q[i] == CW'(MaxWait));
    end

    // While busy, the current grant holder never competes for the next slot.
    rib_prio_pick #(.N(NumMasters), .IW(IW)) u_pick_urg (
        .req      (m_req_i),
        .mask     (urgent),
        .excl_en  (busy),
        .excl_idx (gnt_q),
        .valid    (urg_vld),
        .idx      (urg_idx)
    );

    rib_prio_pick #(.N(NumMasters), .IW(IW)) u_pick_pln (
        .req      (m_req_i),
        .mask     ({NumMasters{1'b1}}),
        .excl_en  (busy),
        .excl_idx (gnt_q),
        .valid    (pln_vld),
        .idx      (pln_idx)
    );

    assign win     = urg_vld ? urg_idx : pln_idx;
    assign any_vld = urg_vld | pln_vld;

    // Next-state / grant selection: grant from IDLE, or hand over on ready.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    state_d = BUSY;
                    gnt_d   = win;
                    load    = 1'b1;
                end
            end
            BUSY: begin
                if (s_ready_i) begin
                    if (any_vld) begin
                        gnt_d = win;
                        load  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux and master-side response steering for the grant holder.
    always_comb begin
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m_data_o  = '0;
        m_ready_o = '0;
        if (busy) begin
            s_req_o          = 1'b1;
            s_we_o           = m_we_i[gnt_q];
            s_addr_o         = m_addr_i[gnt_q];
            s_data_o         = m_data_i[gnt_q];
            m_data_o[gnt_q]  = s_data_i;
            m_ready_o[gnt_q] = s_ready_i;
        end
    end

    // Reset forces the flag low even though requests may still be asserted.
    assign hold_flag_o = rst_ni & (|(CoreMask & m_req_i & ~m_ready_o));

    // State and grant registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // Wait counters: count ungranted request cycles, clear on grant or idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NumMasters; i++) begin
                if (!m_req_i[i] || (busy && gnt_q == IW'(i)) || (load && gnt_d == IW'(i)))
                    cnt_q[i] <= '0;
                else if (cnt_q[i] != CW'(MaxWait))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    // The grant holder must keep requesting until its ready.
    a_gnt_req_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
        busy |-> m_req_i[gnt_q]);

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed bench for rib_arbiter: per-cycle vector table plus starvation and
// mid-transaction reset sequences.
module tb_rib_arbiter;
    import tinyriscv_pkg::*;

    localparam logic [31:0] A0 = 32'h3000_0000, D0 = 32'h0000_00D0;
    localparam logic [31:0] A2 = 32'h4000_0008, D2 = 32'h0000_00D2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_ni;
    logic [2:0][31:0]  m_addr_i, m_data_i, m_data_o;
    logic [2:0]        m_req_i, m_we_i, m_ready_o;
    logic [31:0]       s_addr_o, s_data_o, s_data_i;
    logic              s_we_o, s_req_o, s_ready_i, hold_flag_o;
    logic [31:0]       a1, d1;

    assign m_addr_i = {A2, a1, A0};
    assign m_data_i = {D2, d1, D0};

    rib_arbiter #(.NumMasters(3), .MaxWait(4), .CoreMask(3'b110)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_req_i(m_req_i), .m_we_i(m_we_i),
        .m_data_o(m_data_o), .m_ready_o(m_ready_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_req_o(s_req_o),
        .s_data_i(s_data_i), .s_ready_i(s_ready_i), .hold_flag_o(hold_flag_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  req, we;
        logic        rdy;
        logic [31:0] a1, d1, sd;
        logic        sreq;
        logic [2:0]  mrdy;
        logic        hold;
        logic [31:0] saddr;
        logic        swe;
        logic [31:0] sdo;
        logic [95:0] mdat;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] req, we, input logic rdy,
                                input logic [31:0] va1, vd1, sd, input logic sreq,
                                input logic [2:0] mrdy, input logic hold,
                                input logic [31:0] saddr, input logic swe,
                                input logic [31:0] sdo, input logic [95:0] mdat);
        vec_t v;
        v.req = req; v.we = we; v.rdy = rdy; v.a1 = va1; v.d1 = vd1; v.sd = sd;
        v.sreq = sreq; v.mrdy = mrdy; v.hold = hold; v.saddr = saddr;
        v.swe = swe; v.sdo = sdo; v.mdat = mdat;
        return v;
    endfunction

    task automatic drive(input logic [2:0] req, input logic rdy, input logic [31:0] sd);
        @(negedge clk);
        m_req_i = req; s_ready_i = rdy; s_data_i = sd;
        #2;
    endtask

    vec_t tv[19];
    logic [31:0] exp_a[7];
    logic [2:0]  exp_r[7];

    initial begin
        // single read (m1), idle ready ignored
        tv[0]  = mk(3'b010, 3'b000, 0, 32'h1000_0000, 0, 0,            0, 3'b000, 1, 0, 0, 0, 0);
        tv[1]  = mk(3'b010, 3'b000, 0, 32'h1000_0000, 0, 0,            1, 3'b000, 1, 32'h1000_0000, 0, 0, 0);
        tv[2]  = mk(3'b010, 3'b000, 0, 32'h1000_0000, 0, 0,            1, 3'b000, 1, 32'h1000_0000, 0, 0, 0);
        tv[3]  = mk(3'b010, 3'b000, 1, 32'h1000_0000, 0, 32'hDEADBEEF, 1, 3'b010, 0, 32'h1000_0000, 0, 0,
                    {32'h0, 32'hDEADBEEF, 32'h0});
        tv[4]  = mk(3'b000, 3'b000, 0, 32'h1000_0000, 0, 0,            0, 3'b000, 0, 0, 0, 0, 0);
        tv[5]  = mk(3'b000, 3'b000, 1, 32'h1000_0000, 0, 32'h12345678, 0, 3'b000, 0, 0, 0, 0, 0);
        // simultaneous m0 + m2, back-to-back handover
        tv[6]  = mk(3'b101, 3'b000, 0, 0, 0, 0,                        0, 3'b000, 1, 0, 0, 0, 0);
        tv[7]  = mk(3'b101, 3'b000, 1, 0, 0, 32'hAAAA0000,             1, 3'b001, 1, A0, 0, D0,
                    {64'h0, 32'hAAAA0000});
        tv[8]  = mk(3'b100, 3'b000, 0, 0, 0, 0,                        1, 3'b000, 1, A2, 0, D2, 0);
        tv[9]  = mk(3'b100, 3'b000, 1, 0, 0, 32'hBBBB0000,             1, 3'b100, 0, A2, 0, D2,
                    {32'hBBBB0000, 64'h0});
        tv[10] = mk(3'b000, 3'b000, 0, 0, 0, 0,                        0, 3'b000, 0, 0, 0, 0, 0);
        // m1 write pass-through
        tv[11] = mk(3'b010, 3'b010, 0, 32'h2000_0004, 32'hA5, 0,       0, 3'b000, 1, 0, 0, 0, 0);
        tv[12] = mk(3'b010, 3'b010, 0, 32'h2000_0004, 32'hA5, 0,       1, 3'b000, 1, 32'h2000_0004, 1, 32'hA5, 0);
        tv[13] = mk(3'b010, 3'b010, 1, 32'h2000_0004, 32'hA5, 32'h5A5A, 1, 3'b010, 0, 32'h2000_0004, 1, 32'hA5,
                    {32'h0, 32'h5A5A, 32'h0});
        tv[14] = mk(3'b000, 3'b000, 0, 32'h2000_0004, 32'hA5, 0,       0, 3'b000, 0, 0, 0, 0, 0);
        // JTAG only: hold flag never rises
        tv[15] = mk(3'b001, 3'b000, 0, 0, 0, 0,                        0, 3'b000, 0, 0, 0, 0, 0);
        tv[16] = mk(3'b001, 3'b000, 0, 0, 0, 0,                        1, 3'b000, 0, A0, 0, D0, 0);
        tv[17] = mk(3'b001, 3'b000, 1, 0, 0, 32'h77,                   1, 3'b001, 0, A0, 0, D0, {64'h0, 32'h77});
        tv[18] = mk(3'b000, 3'b000, 0, 0, 0, 0,                        0, 3'b000, 0, 0, 0, 0, 0);

        // reset state
        rst_ni = 1'b0; m_req_i = '0; m_we_i = '0; s_ready_i = 1'b0; s_data_i = '0;
        a1 = '0; d1 = '0;
        #2;
        chk("rst_sreq", s_req_o, 0);
        chk("rst_mrdy", m_ready_o, 0);
        chk("rst_hold", hold_flag_o, 0);
        chk("rst_saddr", s_addr_o, 0);
        chk("rst_mdat", m_data_o, 0);
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;

        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            m_req_i = tv[k].req; m_we_i = tv[k].we; s_ready_i = tv[k].rdy;
            a1 = tv[k].a1; d1 = tv[k].d1; s_data_i = tv[k].sd;
            #2;
            chk($sformatf("v%0d_sreq", k),  s_req_o,     tv[k].sreq);
            chk($sformatf("v%0d_mrdy", k),  m_ready_o,   tv[k].mrdy);
            chk($sformatf("v%0d_hold", k),  hold_flag_o, tv[k].hold);
            chk($sformatf("v%0d_saddr", k), s_addr_o,    tv[k].saddr);
            chk($sformatf("v%0d_swe", k),   s_we_o,      tv[k].swe);
            chk($sformatf("v%0d_sdo", k),   s_data_o,    tv[k].sdo);
            chk($sformatf("v%0d_mdat", k),  m_data_o,    tv[k].mdat);
        end

        // starvation: m0/m1 alternate back-to-back, m2 promoted after 4 waits
        a1 = 32'h1000_0000; d1 = '0; m_we_i = '0;
        exp_a = '{32'h0, A0, 32'h1000_0000, A0, 32'h1000_0000, A2, A0};
        exp_r = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b010, 3'b100, 3'b001};
        for (int c = 0; c < 7; c++) begin
            drive((c == 6) ? 3'b001 : 3'b111, (c != 0), 32'h0);
            chk($sformatf("starve_c%0d_saddr", c), s_addr_o, exp_a[c]);
            chk($sformatf("starve_c%0d_mrdy", c),  m_ready_o, exp_r[c]);
            if (c == 4) chk("starve_cnt_sat", dut.cnt_q[2], 4);
            if (c == 5) chk("starve_cnt_clr", dut.cnt_q[2], 0);
        end
        drive(3'b000, 1'b0, 32'h0);
        chk("starve_drain_sreq", s_req_o, 0);

        // reset while busy with m2
        drive(3'b100, 1'b0, 32'h0);
        chk("rstb_idle_sreq", s_req_o, 0);
        drive(3'b100, 1'b0, 32'h0);
        chk("rstb_busy_saddr", s_addr_o, A2);
        s_ready_i = 1'b1;
        #1 rst_ni = 1'b0;
        #1;
        chk("rstb_sreq", s_req_o, 0);
        chk("rstb_hold", hold_flag_o, 0);
        chk("rstb_mrdy", m_ready_o, 0);
        @(negedge clk);
        m_req_i = 3'b010; s_ready_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        #2;
        chk("rstb_rel_sreq", s_req_o, 0);
        drive(3'b010, 1'b0, 32'h0);
        chk("rstb_fresh_sreq", s_req_o, 1);
        chk("rstb_fresh_saddr", s_addr_o, 32'h1000_0000);
        drive(3'b010, 1'b1, 32'hCAFE);
        chk("rstb_fresh_mrdy", m_ready_o, 3'b010);
        drive(3'b000, 1'b0, 32'h0);
        chk("rstb_end_sreq", s_req_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
